// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//
// Pixel-plot engine that sits between the CPU command port and video RAM.
// Commands {op, x, y, color} are queued in a small FIFO and executed in
// order. A plot does a read-modify-write of one 16-bit VRAM word, so only
// the addressed 4-bit nibble changes. A clear-fill writes every word of the
// 160x120 framebuffer (4 pixels per word, 4800 words) with one color.
//
// Ports
//   sys_clock_i      single clock, rising edge
//   resetb_i         asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (valid/ready, see below)
//   cmd_op_i         00 plot, 01 clear-fill, 1x reserved (accepted, dropped)
//   cmd_x_i, cmd_y_i pixel column / row
//   cmd_color_i      3-bit RGB color
//   vram_addr_o      VRAM word address
//   vram_we_o        VRAM write strobe
//   vram_wdata_o     VRAM write data
//   vram_rdata_i     VRAM read data, valid the cycle after a read address
//   busy_o           FIFO non-empty or engine not idle
//   clip_err_o       sticky flag: an off-screen plot was dropped
//   clip_clr_i       clears clip_err_o (a simultaneous clip event wins)
//   dbg_state_o      current FSM state (IDLE=0, RD=1, WR=2, CLEAR=3)
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o depends only on the registered FIFO
// count, so it does not depend on cmd_valid_i in the same cycle; a held
// command simply waits while the FIFO is full.

module fb_pixel_writer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int FB_WIDTH      = 160,
    parameter int FB_HEIGHT     = 120,
    parameter int WORDS_PER_ROW = 40
) (
    input  logic        sys_clock_i,
    input  logic        resetb_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [7:0]  cmd_x_i,
    input  logic [7:0]  cmd_y_i,
    input  logic [2:0]  cmd_color_i,
    output logic [13:0] vram_addr_o,
    output logic        vram_we_o,
    output logic [15:0] vram_wdata_o,
    input  logic [15:0] vram_rdata_i,
    output logic        busy_o,
    output logic        clip_err_o,
    input  logic        clip_clr_i,
    output logic [1:0]  dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [13:0] LAST_WORD = 14'(WORDS_PER_ROW * FB_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // ---------------- command FIFO ----------------
    logic [20:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign cmd_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge sys_clock_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_op_i, cmd_x_i, cmd_y_i, cmd_color_i};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Head-of-FIFO decode
    logic [20:0] head;
    logic [1:0]  head_op;
    logic [7:0]  head_x, head_y;
    logic [2:0]  head_color;
    logic [13:0] head_addr;
    logic        head_onscreen;

    assign head          = fifo_mem_q[rd_ptr_q];
    assign head_op       = head[20:19];
    assign head_x        = head[18:11];
    assign head_y        = head[10:3];
    assign head_color    = head[2:0];
    assign head_addr     = 14'(head_y) * 14'(WORDS_PER_ROW) + 14'(head_x[7:2]);
    assign head_onscreen = (head_x < 8'(FB_WIDTH)) && (head_y < 8'(FB_HEIGHT));

    // ---------------- engine FSM ----------------
    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;   // target word of the current plot
    logic [1:0]  nib_q, nib_d;     // nibble index x[1:0]
    logic [2:0]  color_q, color_d;
    logic [13:0] cnt_q, cnt_d;     // clear-fill word counter
    logic        clip_q, clip_set;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nib_d        = nib_q;
        color_d      = color_q;
        cnt_d        = cnt_q;
        clip_set     = 1'b0;
        pop          = 1'b0;
        vram_we_o    = 1'b0;
        vram_addr_o  = addr_q;
        vram_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    case (head_op)
                        2'b00: begin
                            if (head_onscreen) begin
                                addr_d  = head_addr;
                                nib_d   = head_x[1:0];
                                color_d = head_color;
                                state_d = RD;
                            end else begin
                                clip_set = 1'b1;
                            end
                        end
                        2'b01: begin
                            color_d = head_color;
                            cnt_d   = '0;
                            state_d = CLEAR;
                        end
                        default: ; // reserved op: consumed and dropped
                    endcase
                end
            end
            RD: begin
                // Read cycle: address only, data returns next cycle.
                state_d = WR;
            end
            WR: begin
                vram_we_o = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    vram_wdata_o[4*i +: 4] = (nib_q == 2'(i)) ? {1'b0, color_q}
                                                              : vram_rdata_i[4*i +: 4];
                end
                state_d = IDLE;
            end
            CLEAR: begin
                vram_we_o    = 1'b1;
                vram_addr_o  = cnt_q;
                vram_wdata_o = {4{1'b0, color_q}};
                if (cnt_q == LAST_WORD) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            nib_q   <= '0;
            color_q <= '0;
            cnt_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
            // A new clip event takes priority over a clear request.
            if (clip_set) begin
                clip_q <= 1'b1;
            end else if (clip_clr_i) begin
                clip_q <= 1'b0;
            end
        end
    end

    assign busy_o      = (count_q != '0) || (state_q != IDLE);
    assign clip_err_o  = clip_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [2:0]  cmd_color;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [15:0] vram_wdata;
  logic [15:0] vram_rdata;
  logic        busy;
  logic        clip_err;
  logic        clip_clr;
  logic [1:0]  dbg_state;

  fb_pixel_writer dut (
    .sys_clock_i  (clk),
    .resetb_i     (resetb),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_x_i      (cmd_x),
    .cmd_y_i      (cmd_y),
    .cmd_color_i  (cmd_color),
    .vram_addr_o  (vram_addr),
    .vram_we_o    (vram_we),
    .vram_wdata_o (vram_wdata),
    .vram_rdata_i (vram_rdata),
    .busy_o       (busy),
    .clip_err_o   (clip_err),
    .clip_clr_i   (clip_clr),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [13:0] wa_q[$];      // observed write addresses
  logic [15:0] wd_q[$];      // observed write data
  logic [13:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          rd_cnt = 0;   // cycles spent in the read state

  // Record the VRAM activity of each completed cycle at the closing edge.
  always @(posedge clk) begin
    if (resetb && vram_we) begin
      wa_q.push_back(vram_addr);
      wd_q.push_back(vram_wdata);
    end
    if (resetb && dbg_state == 2'd1) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a command and hold it until accepted; returns just after the
  // accepting edge with cmd_valid dropped. waited = cycles stalled.
  task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                      input logic [2:0] c, output int waited);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_color = c;
    waited    = 0;
    while (!cmd_ready && waited < 6000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) check("send_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int base;
    int rd0;
    int bad;
    int n;
    int wait5;

    resetb     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_color  = '0;
    vram_rdata = '0;
    clip_clr   = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_op     = 2'($urandom_range(0, 3));
      cmd_x      = 8'($urandom_range(0, 255));
      cmd_y      = 8'($urandom_range(0, 255));
      cmd_color  = 3'($urandom_range(0, 7));
      vram_rdata = 16'($urandom_range(0, 65535));
      clip_clr   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we", {31'd0, vram_we}, 32'd0);
    check("rst_clip", {31'd0, clip_err}, 32'd0);
    check("rst_addr", {18'd0, vram_addr}, 32'd0);
    check("rst_wdata", {16'd0, vram_wdata}, 32'd0);
    cmd_valid = 1'b0;
    clip_clr  = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_writes", wa_q.size(), 32'd0);
    check("post_rst_reads", rd_cnt, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single plot x=5 y=2 color=6 over 16'hFFFF
    vram_rdata = 16'hFFFF;
    send(2'b00, 8'd5, 8'd2, 3'd6, w);
    @(negedge clk);
    check("plot_busy", {31'd0, busy}, 32'd1);
    check("plot_idle_we", {31'd0, vram_we}, 32'd0);
    @(negedge clk);
    check("plot_rd_state", {30'd0, dbg_state}, 32'd1);
    check("plot_rd_we", {31'd0, vram_we}, 32'd0);
    check("plot_rd_addr", {18'd0, vram_addr}, 32'd81);
    @(negedge clk);
    check("plot_wr_we", {31'd0, vram_we}, 32'd1);
    check("plot_wr_addr", {18'd0, vram_addr}, 32'd81);
    check("plot_wr_data", {16'd0, vram_wdata}, 32'h0000FF6F);
    @(negedge clk);
    check("plot_busy_fall", {31'd0, busy}, 32'd0);
    check("plot_done_we", {31'd0, vram_we}, 32'd0);

    // Off-screen plots
    base = wa_q.size();
    rd0  = rd_cnt;
    send(2'b00, 8'd160, 8'd0, 3'd2, w);
    send(2'b00, 8'd0, 8'd120, 3'd2, w);
    repeat (2) @(negedge clk);
    check("clip_busy", {31'd0, busy}, 32'd0);
    check("clip_flag", {31'd0, clip_err}, 32'd1);
    check("clip_no_write", wa_q.size() - base, 32'd0);
    check("clip_no_read", rd_cnt - rd0, 32'd0);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    check("clip_cleared", {31'd0, clip_err}, 32'd0);

    // Clip event while clip_clr is held: set wins
    clip_clr = 1'b1;
    send(2'b00, 8'd200, 8'd5, 3'd1, w);
    repeat (2) @(negedge clk);
    check("clip_set_wins", {31'd0, clip_err}, 32'd1);
    clip_clr = 1'b0;
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    check("clip_cleared2", {31'd0, clip_err}, 32'd0);

    // Reserved op is consumed silently
    base = wa_q.size();
    rd0  = rd_cnt;
    send(2'b10, 8'd5, 8'd5, 3'd5, w);
    repeat (2) @(negedge clk);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_no_write", wa_q.size() - base, 32'd0);
    check("rsv_no_read", rd_cnt - rd0, 32'd0);
    check("rsv_no_clip", {31'd0, clip_err}, 32'd0);

    // Last on-screen pixel: x=159 y=119 -> word 4799, nibble 3
    base = wa_q.size();
    send(2'b00, 8'd159, 8'd119, 3'd5, w);
    wait_idle("edge_idle", 20);
    check("edge_count", wa_q.size() - base, 32'd1);
    if (wa_q.size() > base) begin
      check("edge_addr", {18'd0, wa_q[base]}, 32'd4799);
      check("edge_data", {16'd0, wd_q[base]}, 32'h00005FFF);
    end

    // Clear-fill with color 3
    base = wa_q.size();
    rd0  = rd_cnt;
    send(2'b01, 8'd0, 8'd0, 3'd3, w);
    wait_idle("clear_idle", 6000);
    check("clear_count", wa_q.size() - base, 32'd4800);
    bad = 0;
    for (int i = 0; i < 4800 && base + i < wa_q.size(); i++) begin
      if (wa_q[base+i] !== 14'(i) || wd_q[base+i] !== 16'h3333) bad++;
    end
    check("clear_words", bad, 32'd0);
    check("clear_no_read", rd_cnt - rd0, 32'd0);

    // Backpressure: clear then 6 plots over zero read data
    vram_rdata = 16'h0000;
    exp_addr_q = '{14'd0, 14'd0, 14'd41, 14'd41, 14'd122, 14'd39};
    exp_data_q = '{16'h0001, 16'h0020, 16'h0300, 16'h4000, 16'h0005, 16'h7000};
    base = wa_q.size();
    send(2'b01, 8'd0, 8'd0, 3'd0, w);
    send(2'b00, 8'd0, 8'd0, 3'd1, w);
    send(2'b00, 8'd1, 8'd0, 3'd2, w);
    send(2'b00, 8'd6, 8'd1, 3'd3, w);
    send(2'b00, 8'd7, 8'd1, 3'd4, w);
    check("bp_four_no_stall", w, 32'd0);
    check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
    send(2'b00, 8'd8, 8'd3, 3'd5, wait5);
    check("bp_5th_waited", {31'd0, wait5 > 4700}, 32'd1);
    check("bp_5th_after_clear", {31'd0, (wa_q.size() - base) >= 4800}, 32'd1);
    send(2'b00, 8'd159, 8'd0, 3'd7, w);
    wait_idle("bp_idle", 100);
    check("bp_count", wa_q.size() - base, 32'd4806);
    bad = 0;
    if (wa_q.size() - base == 4806) begin
      for (int i = 0; i < 6; i++) begin
        if (wa_q[base+4800+i] !== exp_addr_q[i] || wd_q[base+4800+i] !== exp_data_q[i]) bad++;
      end
    end else begin
      bad = 1;
    end
    check("bp_plot_order", bad, 32'd0);

    // Reset in the middle of a clear, with plots queued behind it
    base = wa_q.size();
    send(2'b01, 8'd0, 8'd0, 3'd1, w);
    send(2'b00, 8'd10, 8'd10, 3'd2, w);
    send(2'b00, 8'd11, 8'd10, 3'd2, w);
    n = 0;
    while ((wa_q.size() - base) < 1000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", {31'd0, (wa_q.size() - base) >= 1000}, 32'd1);
    check("mid_we_before", {31'd0, vram_we}, 32'd1);
    resetb = 1'b0;
    #1;
    check("mid_we_async", {31'd0, vram_we}, 32'd0);
    check("mid_busy_rst", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    base = wa_q.size();
    repeat (6) @(negedge clk);
    check("mid_busy_after", {31'd0, busy}, 32'd0);
    check("mid_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("mid_no_writes", wa_q.size() - base, 32'd0);
    check("mid_state_idle", {30'd0, dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
